// File: rtl/frame_loader.sv
// Double-buffered 8x8 RGB frame loader.
// A host streams pixels in row-major order into the back buffer while the
// scanner reads rows from the front buffer. A completed frame waits in the
// back buffer until the scanner's end-of-frame pulse, then the buffers swap,
// so the displayed image never mixes two frames.
module frame_loader #(
    parameter int ROW_NUM = 8,
    parameter int COL_NUM = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic [2:0]  pix_data_i,
    input  logic        sof_i,
    input  logic        frame_end_i,
    input  logic [2:0]  rd_row_i,
    output logic [23:0] rd_data_o,
    output logic        swap_pending_o,
    output logic [7:0]  frame_cnt_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    localparam int        NPIX     = ROW_NUM * COL_NUM;
    localparam logic [5:0] LAST_PTR = 6'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] wr_ptr_q, wr_ptr_d;
    logic       fb_sel;
    logic       back_sel;
    logic       xfer;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       set_err;
    logic       swap;

    // Two frame buffers, one 3-bit pixel per address; address = {row, col}.
    logic [NPIX-1:0][2:0] buf_q [2];

    assign pix_ready_o    = (state_q != PENDING);
    assign swap_pending_o = (state_q == PENDING);
    assign xfer           = pix_valid_i && pix_ready_o;
    assign back_sel       = ~fb_sel;

    // State register, write pointer, buffer select, frame counter.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fb_sel      <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            if (swap) begin
                fb_sel      <= ~fb_sel;
                frame_cnt_o <= frame_cnt_o + 8'd1;
            end
        end
    end

    // Next-state logic: decides what each transfer does and when to swap.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        set_err  = 1'b0;
        swap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (sof_i) begin
                        wr_en    = 1'b1;
                        wr_addr  = '0;
                        wr_ptr_d = 6'd1;
                        state_d  = WRITE;
                    end else begin
                        // Pixel without a frame start is dropped.
                        set_err = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (sof_i) begin
                        // Early restart: abandon the partial frame.
                        set_err  = 1'b1;
                        wr_addr  = '0;
                        wr_ptr_d = 6'd1;
                    end else if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                        state_d  = PENDING;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 6'd1;
                    end
                end
            end
            PENDING: begin
                if (frame_end_i) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer storage: writes land only in the back buffer.
    // NOTE: the buffers are reset along with the control state because a
    // cleared display after reset is visible behaviour, not just hygiene.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (wr_en) begin
            buf_q[back_sel][wr_addr] <= pix_data_i;
        end
    end

    // Registered row read from the front buffer (one-cycle latency).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= buf_q[fb_sel][{rd_row_i, 3'b000} +: COL_NUM];
        end
    end

    // Sticky error flag; a new error wins over a clear in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (set_err) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: directed scenarios plus randomized
// traffic, compared every cycle against a frame-level reference model.
module tb_frame_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [2:0]  pix_data = '0;
    logic        sof = 1'b0;
    logic        frame_end = 1'b0;
    logic [2:0]  rd_row = '0;
    logic [23:0] rd_data;
    logic        swap_pending;
    logic [7:0]  frame_cnt;
    logic        err;
    logic        err_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    frame_loader dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pix_valid_i    (pix_valid),
        .pix_ready_o    (pix_ready),
        .pix_data_i     (pix_data),
        .sof_i          (sof),
        .frame_end_i    (frame_end),
        .rd_row_i       (rd_row),
        .rd_data_o      (rd_data),
        .swap_pending_o (swap_pending),
        .frame_cnt_o    (frame_cnt),
        .err_o          (err),
        .err_clr_i      (err_clr)
    );

    always #10 clk = ~clk;

    // Reference model: two 64-pixel images, which one is shown, and where the
    // host is in filling the hidden one.
    logic [2:0]  m_img [2][64];
    bit          m_front;
    bit          m_fill;      // a frame is being received
    bit          m_pend;      // a full frame waits for the swap
    int          m_idx;       // next pixel index within the frame
    int          m_cnt;
    bit          m_err;
    logic [23:0] m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] m_row(input bit b, input int r);
        logic [23:0] v;
        for (int c = 0; c < 8; c++) v[c*3 +: 3] = m_img[b][r*8 + c];
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++) m_img[b][i] = '0;
        m_front = 0; m_fill = 0; m_pend = 0; m_idx = 0;
        m_cnt = 0; m_err = 0; m_rd = '0;
    endtask

    // Apply one clock edge's worth of behaviour using the current inputs.
    task automatic model_edge();
        bit do_swap;
        bit new_err;
        do_swap = m_pend && frame_end;
        new_err = 0;
        m_rd = m_row(m_front, int'(rd_row));
        if (pix_valid && !m_pend) begin
            if (sof) begin
                if (m_fill) new_err = 1;
                m_img[~m_front][0] = pix_data;
                m_idx  = 1;
                m_fill = 1;
            end else if (!m_fill) begin
                new_err = 1;
            end else begin
                m_img[~m_front][m_idx] = pix_data;
                m_idx++;
                if (m_idx == 64) begin
                    m_fill = 0;
                    m_pend = 1;
                    m_idx  = 0;
                end
            end
        end
        if (do_swap) begin
            m_front = ~m_front;
            m_cnt   = (m_cnt + 1) % 256;
            m_pend  = 0;
        end
        if (new_err) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/ready"}, pix_ready, !m_pend);
        check({tag, "/pend"}, swap_pending, m_pend);
        check({tag, "/cnt"}, frame_cnt, m_cnt[7:0]);
        check({tag, "/err"}, err, m_err);
        check({tag, "/rd"}, rd_data, m_rd);
    endtask

    task automatic cycle(input bit v, input logic [2:0] d, input bit s, input bit fe,
                         input logic [2:0] row, input bit clr);
        pix_valid = v; pix_data = d; sof = s; frame_end = fe; rd_row = row; err_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        pix_valid = 0; sof = 0; frame_end = 0; err_clr = 0;
        rst = 1;
        #2;
        model_reset();
        check_outputs("rst");
        check("rst/rd0", rd_data, 24'h0);
        @(posedge clk);
        #5;
        rst = 0;
    endtask

    // n consecutive transfers; first carries sof, optional frame_end on last.
    task automatic push(input int n, input bit rnd, input logic [2:0] val, input bit fe_last);
        for (int i = 0; i < n; i++)
            cycle(1, rnd ? 3'($urandom) : val, i == 0, fe_last && (i == n - 1),
                  3'($urandom), 0);
    endtask

    task automatic read_rows(input string tag, input logic [23:0] exp);
        for (int r = 0; r < 8; r++) begin
            cycle(0, 3'd0, 0, 0, 3'(r), 0);
            check(tag, rd_data, exp);
        end
    endtask

    initial begin
        int c0;
        do_reset();

        // Single frame of red, swap, read every row.
        push(64, 0, 3'b001, 0);
        check("s1/pend_after_64", swap_pending, 1);
        cycle(0, 3'd0, 0, 1, 3'd0, 0);
        check("s1/pend_after_fe", swap_pending, 0);
        check("s1/cnt", frame_cnt, 8'd1);
        read_rows("s1/row", 24'h249249);

        // Frame A white shown; frame B black loaded but never swapped.
        push(64, 0, 3'b111, 0);
        cycle(0, 3'd0, 0, 1, 3'd0, 0);
        push(64, 0, 3'b000, 0);
        cycle(0, 3'd0, 0, 0, 3'd0, 0);
        check("s2/ready_blocked", pix_ready, 0);
        read_rows("s2/row", 24'hFFFFFF);

        // Pixel without sof in IDLE; error set wins over clear; then clear.
        do_reset();
        cycle(1, 3'b101, 0, 0, 3'd0, 0);
        check("s3/err_set", err, 1);
        read_rows("s3/row", 24'h0);
        cycle(1, 3'b011, 0, 0, 3'd0, 1);
        check("s3/err_prio", err, 1);
        cycle(0, 3'd0, 0, 0, 3'd0, 1);
        check("s3/err_clr", err, 0);

        // Early restart after 30 pixels; only the restarted frame is shown.
        push(30, 0, 3'b101, 0);
        push(64, 0, 3'b010, 0);
        check("s4/err", err, 1);
        cycle(0, 3'd0, 0, 1, 3'd0, 0);
        read_rows("s4/row", 24'h492492);

        // frame_end coincident with last pixel does not swap.
        c0 = m_cnt;
        push(64, 1, 3'd0, 1);
        check("s5/pend", swap_pending, 1);
        check("s5/no_swap", frame_cnt, 8'(c0));
        cycle(0, 3'd0, 0, 1, 3'd0, 0);
        check("s5/swap", frame_cnt, 8'(c0 + 1));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit v, s, fe, clr;
            v   = $urandom_range(0, 99) < 80;
            s   = (m_fill || m_pend) ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 60);
            fe  = $urandom_range(0, 99) < 8;
            clr = $urandom_range(0, 99) < 5;
            cycle(v, 3'($urandom), s, fe, 3'($urandom), clr);
        end

        // Drive the frame counter through its wrap.
        if (m_fill || m_pend) begin
            push(64, 1, 3'd0, 0);
            cycle(0, 3'd0, 0, 1, 3'd0, 0);
        end
        while (m_cnt != 255) begin
            push(64, 1, 3'd0, 0);
            cycle(0, 3'd0, 0, 1, 3'd0, 0);
        end
        check("s6/cnt255", frame_cnt, 8'd255);
        push(64, 1, 3'd0, 0);
        cycle(0, 3'd0, 0, 1, 3'd0, 0);
        check("s6/cnt_wrap", frame_cnt, 8'd0);

        // Reset while a frame is pending.
        push(64, 0, 3'b110, 0);
        check("s7/pend", swap_pending, 1);
        do_reset();
        check("s7/pend0", swap_pending, 0);
        check("s7/cnt0", frame_cnt, 8'd0);
        check("s7/ready", pix_ready, 1);

        // First transfer after reset is honoured.
        push(64, 0, 3'b100, 0);
        cycle(0, 3'd0, 0, 1, 3'd0, 0);
        read_rows("s8/row", 24'h924924);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
